// File: rtl/demux8_rr_ctrl.sv
// rtl/demux8_rr_ctrl.sv - round-robin burst scheduler for the 1-to-8 demux datapath
//
// Hands one valid/ready input stream to one of eight channels at a time for
// BURST beats, skipping disabled channels and rotating among enabled ones.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_data     upstream beat
//   in_ready             upstream beat accepted this cycle
//   en[7:0]              channel enable mask
//   out_ready[7:0]       per-channel sink ready
//   out_valid[7:0]       per-channel valid (one-hot or zero)
//   out_data             in_data broadcast to all channels
//   sel[2:0]             currently granted channel
//   last                 handshake of the final beat of a burst
//   busy                 scheduler not idle
module demux8_rr_ctrl #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [7:0]    en,
  input  logic [7:0]    out_ready,
  output logic [7:0]    out_valid,
  output logic [DW-1:0] out_data,
  output logic [2:0]    sel,
  output logic          last,
  output logic          busy
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEEK = 2'd1;
  localparam logic [1:0] XFER = 2'd2;

  logic [1:0]    state;
  logic [2:0]    ptr;
  logic [CW-1:0] cnt;
  logic [2:0]    pick;
  logic          live;
  logic          hs;

  // First enabled channel at or after ptr, wrapping modulo 8. Scanning from
  // the far end lets the nearest candidate overwrite the others.
  always_comb begin
    logic [2:0] idx;
    pick = ptr;
    idx  = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (en[idx]) pick = idx;
    end
  end

  // Outputs are gated by rst_n so nothing leaks out while reset is held,
  // even in the first reset cycle when state has not yet been cleared.
  assign live      = rst_n && (state == XFER) && en[sel];
  assign in_ready  = live && out_ready[sel];
  assign out_valid = (live && in_valid) ? (8'd1 << sel) : 8'd0;
  assign hs        = in_valid && in_ready;
  assign last      = hs && (cnt == CNT_LAST);
  assign busy      = rst_n && (state != IDLE);
  assign out_data  = in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 3'd0;
      ptr   <= 3'd0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && (|en)) state <= SEEK;
        end
        SEEK: begin
          if (|en) begin
            sel   <= pick;
            cnt   <= '0;
            state <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (!en[sel]) begin
            // Granted channel vanished: drop the partial burst and move on.
            ptr   <= sel + 3'd1;
            state <= IDLE;
          end else if (hs) begin
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              ptr   <= sel + 3'd1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/demux8_rr_ctrl.md
# demux8_rr_ctrl

Round-robin burst scheduler for the 1-to-8 demultiplexer datapath. It accepts a single valid/ready input stream and hands it to one of eight output channels at a time, for a fixed burst length. It skips channels that are disabled and rotates fairly among the enabled ones. The block owns the 3-bit channel select and the per-channel valid qualification that the demux fabric consumes.

## Interface
Parameters:
- DW, 8: data width of the stream.
- BURST, 4: beats sent to a channel before the grant rotates. Legal range is 1..256.

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream beat available.
- in_data  input  DW  upstream beat.
- in_ready  output  1  upstream beat accepted this cycle.
- en  input  8  channel enable mask; bit i enables channel i.
- out_ready  input  8  per-channel sink ready.
- out_valid  output  8  per-channel valid; at most one bit is high.
- out_data  output  DW  equals in_data; broadcast to all channels.
- sel  output  3  currently granted channel (registered).
- last  output  1  high on the handshake of the final beat of a burst.
- busy  output  1  high when state is not IDLE.

## Operation
- Registered state: state (IDLE, SEEK, XFER), sel[2:0], ptr[2:0] (search start point), cnt (width $clog2(BURST), minimum 1 bit).
- Handshake definition: hs = in_valid & in_ready.
- IDLE:
  - If in_valid and |en, go to SEEK. Otherwise stay in IDLE.
- SEEK (one cycle):
  - sel <= the first index i with en[i]=1, searching ptr, ptr+1, ... with modulo-8 wrap.
  - cnt <= 0; go to XFER.
  - If en==0 in this cycle, go to IDLE and leave sel unchanged.
- XFER:
  - out_valid[i] = (i==sel) & en[sel] & in_valid.
  - in_ready = en[sel] & out_ready[sel].
  - On hs: cnt <= cnt+1.
  - On hs with cnt==BURST-1: last=1, ptr <= sel+1 (7 wraps to 0), go to IDLE.
  - If en[sel]==0: no handshake is possible. ptr <= sel+1 and go to IDLE, abandoning the partial burst. No data is lost.
- In IDLE and SEEK: out_valid=0, in_ready=0, last=0.
- Boundary cases:
  - en changes during XFER are sampled every cycle; they have no effect unless bit sel drops.
  - BURST=1: every handshake is last.
  - A single enabled channel is re-granted after every burst.
  - An out_ready stall holds cnt; in_data must be held by upstream per valid/ready rules.

## Timing
- Reset values: state=IDLE, sel=0, ptr=0, cnt=0.
- Outputs under reset: out_valid=0, in_ready=0, last=0, busy=0, out_data=in_data.
- Reset mid-burst returns to IDLE on the next edge and discards cnt and ptr.
- Combinational paths:
  - in_valid → out_valid.
  - out_ready → in_ready.
  - in_data → out_data.
  - No register lies in the data path; beat latency is 0 cycles.
- Grant latency: in_valid rising in IDLE gives first possible handshake 2 cycles later (IDLE→SEEK→XFER).
- Steady state with everything ready: BURST beats, then a 2-cycle gap (IDLE, SEEK) before the next channel. Throughput is BURST/(BURST+2).
- sel changes only on the SEEK→XFER edge and is stable throughout XFER.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, in_ready=0, sel=0, busy=0. Release rst_n → first handshake on cycle 2 after release, to channel 0.
- Full rotation: BURST=4, en=8'hFF, all ready, continuous data 0,1,2,... → channels 0..7 each receive exactly 4 consecutive values, then the order wraps to 0. last is high on beats 3, 7, 11, ...; 2 idle cycles between bursts.
- Sparse mask: en=8'b1010_0000 → grants alternate 5, 7, 5, 7. No out_valid on any other bit.
- Backpressure: out_ready[sel] low for 5 cycles mid-burst → in_ready=0 and cnt frozen. The burst completes with exactly BURST beats once ready returns.
- Disable mid-burst: clear en[sel] after 2 of 4 beats → the next cycle enters IDLE. The next grant goes to the following enabled channel with a fresh count of 4.
- Empty mask and mid-burst reset: en=0 with in_valid=1 → stays IDLE indefinitely. Asserting rst_n=0 during XFER → IDLE on the next edge; after release the grant restarts at channel 0.
